// File: rtl/alu_issue_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_if
//  Description : Request, ALU-drive and response bundle for alu_issue.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_if #(
    parameter int N = 32
);
    logic         req_valid;
    logic         req_ready;
    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic         funct7b5;
    logic [N-1:0] rs1_val;
    logic [N-1:0] rs2_val;
    logic [N-1:0] imm;

    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_sel;
    logic [N-1:0] alu_out;
    logic         alu_zero;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic         rsp_zero;
    logic         rsp_taken;
    logic         rsp_illegal;

    // Issue block view: consumes requests and ALU results, drives the ALU and responses.
    modport slave (
        input  req_valid, opcode, funct3, funct7b5, rs1_val, rs2_val, imm,
        output req_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_out, alu_zero,
        output rsp_valid, rsp_result, rsp_zero, rsp_taken, rsp_illegal,
        input  rsp_ready
    );

    // Surrounding datapath view: decode stage, ALU and response consumer.
    modport master (
        output req_valid, opcode, funct3, funct7b5, rs1_val, rs2_val, imm,
        input  req_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_out, alu_zero,
        input  rsp_valid, rsp_result, rsp_zero, rsp_taken, rsp_illegal,
        output rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue
//  Description : Decodes an RV32I slice, drives the ALU from registers and
//                returns the captured result over a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue #(
    parameter int N = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.slave  bus,
    output logic [7:0]  illegal_cnt
);
    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    localparam logic [3:0] c_SEL_AND = 4'd0;
    localparam logic [3:0] c_SEL_OR  = 4'd1;
    localparam logic [3:0] c_SEL_ADD = 4'd2;
    localparam logic [3:0] c_SEL_SUB = 4'd6;
    localparam logic [3:0] c_SEL_ILL = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         w_accept;
    logic         w_capture;

    logic [3:0]   w_sel;
    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    logic         w_illegal;
    logic         w_use_imm;
    logic         w_beq;
    logic         w_bne;

    logic [N-1:0] r_alu_a;
    logic [N-1:0] r_alu_b;
    logic [3:0]   r_alu_sel;
    logic         r_beq;
    logic         r_bne;
    logic         r_illegal;
    logic [N-1:0] r_rsp_result;
    logic         r_rsp_zero;
    logic         r_rsp_taken;
    logic         r_rsp_illegal;
    logic [7:0]   r_illegal_cnt;

    // Decode: anything not explicitly recognised stays illegal with zeroed operands.
    always_comb begin
        w_sel     = c_SEL_ILL;
        w_illegal = 1'b1;
        w_use_imm = 1'b0;
        w_beq     = 1'b0;
        w_bne     = 1'b0;
        w_a       = '0;
        w_b       = '0;
        case (bus.opcode)
            c_OP_R: begin
                w_illegal = 1'b0;
                case (bus.funct3)
                    3'b000:  w_sel = bus.funct7b5 ? c_SEL_SUB : c_SEL_ADD;
                    3'b111:  w_sel = c_SEL_AND;
                    3'b110:  w_sel = c_SEL_OR;
                    default: begin
                        w_sel     = c_SEL_ILL;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            c_OP_I: begin
                w_illegal = 1'b0;
                w_use_imm = 1'b1;
                case (bus.funct3)
                    3'b000:  w_sel = c_SEL_ADD;
                    3'b111:  w_sel = c_SEL_AND;
                    3'b110:  w_sel = c_SEL_OR;
                    default: begin
                        w_sel     = c_SEL_ILL;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            c_OP_LOAD, c_OP_STORE: begin
                w_illegal = 1'b0;
                w_use_imm = 1'b1;
                w_sel     = c_SEL_ADD;
            end
            c_OP_BRANCH: begin
                if (bus.funct3 == 3'b000 || bus.funct3 == 3'b001) begin
                    w_illegal = 1'b0;
                    w_sel     = c_SEL_SUB;
                    w_beq     = (bus.funct3 == 3'b000);
                    w_bne     = (bus.funct3 == 3'b001);
                end
            end
            default: ;
        endcase
        if (!w_illegal) begin
            w_a = bus.rs1_val;
            w_b = w_use_imm ? bus.imm : bus.rs2_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_sel     <= 4'd0;
            r_beq         <= 1'b0;
            r_bne         <= 1'b0;
            r_illegal     <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_zero    <= 1'b0;
            r_rsp_taken   <= 1'b0;
            r_rsp_illegal <= 1'b0;
            r_illegal_cnt <= 8'd0;
        end else begin
            if (w_accept) begin
                r_alu_a   <= w_a;
                r_alu_b   <= w_b;
                r_alu_sel <= w_sel;
                r_beq     <= w_beq;
                r_bne     <= w_bne;
                r_illegal <= w_illegal;
                if (w_illegal && r_illegal_cnt != 8'hFF) begin
                    r_illegal_cnt <= r_illegal_cnt + 8'd1;
                end
            end
            if (w_capture) begin
                r_rsp_result  <= bus.alu_out;
                r_rsp_zero    <= bus.alu_zero;
                r_rsp_taken   <= (r_beq & bus.alu_zero) | (r_bne & ~bus.alu_zero);
                r_rsp_illegal <= r_illegal;
            end
        end
    end

    assign bus.req_ready   = (r_state == S_IDLE);
    assign bus.rsp_valid   = (r_state == S_RESP);
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_sel     = r_alu_sel;
    assign bus.rsp_result  = r_rsp_result;
    assign bus.rsp_zero    = r_rsp_zero;
    assign bus.rsp_taken   = r_rsp_taken;
    assign bus.rsp_illegal = r_rsp_illegal;
    assign illegal_cnt     = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue
//  Description : Randomized self-checking bench for alu_issue with a
//                mnemonic-level reference model and a behavioural ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;
    localparam int N = 32;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] result;
        logic        zero;
        logic        taken;
        logic        illegal;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] illegal_cnt;
    int         n_checks;
    int         n_errors;
    int         exp_cnt;

    alu_issue_if #(.N(N)) bus ();

    alu_issue #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU sitting on the registered operand bus.
    always_comb begin
        case (bus.alu_sel)
            4'd0:    bus.alu_out = bus.alu_a & bus.alu_b;
            4'd1:    bus.alu_out = bus.alu_a | bus.alu_b;
            4'd2:    bus.alu_out = bus.alu_a + bus.alu_b;
            4'd6:    bus.alu_out = bus.alu_a - bus.alu_b;
            default: bus.alu_out = '0;
        endcase
        bus.alu_zero = (bus.alu_out == '0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Instruction semantics expressed by mnemonic, not by select encoding.
    function automatic exp_t ref_model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                       input logic [31:0] rs1, input logic [31:0] rs2,
                                       input logic [31:0] imm);
        exp_t e;
        e.sel = 4'd15; e.a = '0; e.b = '0; e.result = '0;
        e.zero = 1'b0; e.taken = 1'b0; e.illegal = 1'b1;
        if (op == 7'b0110011 && (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6)) begin
            e.illegal = 1'b0; e.a = rs1; e.b = rs2;
            if (f3 == 3'd0 && !f7)     begin e.sel = 4'd2; e.result = rs1 + rs2; end
            else if (f3 == 3'd0)       begin e.sel = 4'd6; e.result = rs1 - rs2; end
            else if (f3 == 3'd7)       begin e.sel = 4'd0; e.result = rs1 & rs2; end
            else                       begin e.sel = 4'd1; e.result = rs1 | rs2; end
        end else if (op == 7'b0010011 && (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6)) begin
            e.illegal = 1'b0; e.a = rs1; e.b = imm;
            if (f3 == 3'd0)      begin e.sel = 4'd2; e.result = rs1 + imm; end
            else if (f3 == 3'd7) begin e.sel = 4'd0; e.result = rs1 & imm; end
            else                 begin e.sel = 4'd1; e.result = rs1 | imm; end
        end else if (op == 7'b0000011 || op == 7'b0100011) begin
            e.illegal = 1'b0; e.a = rs1; e.b = imm; e.sel = 4'd2; e.result = rs1 + imm;
        end else if (op == 7'b1100011 && (f3 == 3'd0 || f3 == 3'd1)) begin
            e.illegal = 1'b0; e.a = rs1; e.b = rs2; e.sel = 4'd6; e.result = rs1 - rs2;
            e.taken = (f3 == 3'd0) ? (rs1 == rs2) : (rs1 != rs2);
        end
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    task automatic wait_ready();
        int w;
        w = 0;
        while (!bus.req_ready && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        check("req_ready_wait", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic drive_req(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
        bus.opcode = op; bus.funct3 = f3; bus.funct7b5 = f7;
        bus.rs1_val = rs1; bus.rs2_val = rs2; bus.imm = imm;
        bus.req_valid = 1'b1;
    endtask

    task automatic run_txn(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] imm, input bit early_ready, input int hold);
        exp_t e;
        e = ref_model(op, f3, f7, rs1, rs2, imm);
        wait_ready();
        drive_req(op, f3, f7, rs1, rs2, imm);
        bus.rsp_ready = early_ready;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (e.illegal && exp_cnt < 255) exp_cnt++;
        check({tag, ".sel"}, 32'(bus.alu_sel), 32'(e.sel));
        check({tag, ".a"}, bus.alu_a, e.a);
        check({tag, ".b"}, bus.alu_b, e.b);
        check({tag, ".exec_req_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, ".exec_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, ".result"}, bus.rsp_result, e.result);
        check({tag, ".zero"}, 32'(bus.rsp_zero), 32'(e.zero));
        check({tag, ".taken"}, 32'(bus.rsp_taken), 32'(e.taken));
        check({tag, ".illegal"}, 32'(bus.rsp_illegal), 32'(e.illegal));
        check({tag, ".cnt"}, 32'(illegal_cnt), 32'(exp_cnt));
        // Stall the consumer while a competing request is offered.
        for (int i = 0; i < hold; i++) begin
            bus.rsp_ready = 1'b0;
            drive_req(7'b0110011, 3'd0, 1'b0, 32'hAAAA, 32'h5555, 32'd0);
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, ".hold_req_ready"}, 32'(bus.req_ready), 32'd0);
            check({tag, ".hold_result"}, bus.rsp_result, e.result);
            check({tag, ".hold_sel"}, 32'(bus.alu_sel), 32'(e.sel));
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check({tag, ".done_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, ".done_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, ".done_result_held"}, bus.rsp_result, e.result);
    endtask

    initial begin
        logic [6:0]  op;
        logic [31:0] r1;
        logic [31:0] r2;
        n_checks = 0; n_errors = 0; exp_cnt = 0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
        bus.opcode = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0;
        bus.rs1_val = '0; bus.rs2_val = '0; bus.imm = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.req_ready", 32'(bus.req_ready), 32'd1);
        check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst.alu_a", bus.alu_a, 32'd0);
        check("rst.alu_b", bus.alu_b, 32'd0);
        check("rst.alu_sel", 32'(bus.alu_sel), 32'd0);
        check("rst.result", bus.rsp_result, 32'd0);
        check("rst.flags", {29'd0, bus.rsp_zero, bus.rsp_taken, bus.rsp_illegal}, 32'd0);
        check("rst.cnt", 32'(illegal_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn("add", 7'b0110011, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 1'b0, 0);
        run_txn("sub", 7'b0110011, 3'd0, 1'b1, 32'd5, 32'd7, 32'd0, 1'b0, 0);
        run_txn("beq", 7'b1100011, 3'd0, 1'b0, 32'h1234, 32'h1234, 32'd0, 1'b0, 0);
        run_txn("bne", 7'b1100011, 3'd1, 1'b0, 32'h1234, 32'h1234, 32'd0, 1'b0, 0);
        run_txn("ori", 7'b0010011, 3'd6, 1'b1, 32'hF0, 32'hDEAD, 32'h0F, 1'b0, 0);
        run_txn("load", 7'b0000011, 3'd2, 1'b0, 32'h100, 32'd0, 32'hFFFFFFFC, 1'b0, 0);
        run_txn("ill_r", 7'b0110011, 3'd1, 1'b0, 32'd9, 32'd3, 32'd0, 1'b0, 0);
        run_txn("bp", 7'b0110011, 3'd7, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 5);
        run_txn("early", 7'b0100011, 3'd5, 1'b0, 32'h40, 32'd0, 32'h8, 1'b1, 0);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 5))
                0: op = 7'b0110011;
                1: op = 7'b0010011;
                2: op = 7'b0000011;
                3: op = 7'b0100011;
                4: op = 7'b1100011;
                default: op = 7'($urandom);
            endcase
            r1 = $urandom;
            r2 = ($urandom_range(0, 1) == 1) ? r1 : $urandom;
            run_txn("rand", op, 3'($urandom), 1'($urandom), r1, r2, $urandom,
                    1'($urandom), $urandom_range(0, 2));
        end

        for (int i = 0; i < 300; i++) begin
            run_txn("sat", 7'b1111111, 3'($urandom), 1'b0, $urandom, $urandom, $urandom, 1'b0, 0);
        end
        check("sat.final", 32'(illegal_cnt), 32'd255);

        // Asynchronous reset while the request is in EXEC.
        wait_ready();
        drive_req(7'b0110011, 3'd0, 1'b0, 32'd3, 32'd4, 32'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check("arst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("arst.req_ready", 32'(bus.req_ready), 32'd1);
        check("arst.alu_sel", 32'(bus.alu_sel), 32'd0);
        check("arst.alu_a", bus.alu_a, 32'd0);
        check("arst.cnt", 32'(illegal_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn("post_rst", 7'b0110011, 3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_issue.md
# alu_issue

Request-side driver for the datapath ALU. It accepts one decoded RV32I instruction slice per handshake. It derives the ALU operation select and operands, drives the ALU's A/B/sel inputs from registers, and captures the ALU result and zero flag one cycle later. It then returns them over a valid/ready response port with a branch-taken bit and an illegal-op indication. It sits between the decode stage and the ALU in the multi-cycle datapath.

## Interface
- n, 32, datapath width (operands, immediate, result)
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- opcode  in  7  instruction opcode
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- rs1_val  in  n  source register 1 value
- rs2_val  in  n  source register 2 value
- imm  in  n  sign-extended immediate
- alu_a  out  n  registered ALU operand A
- alu_b  out  n  registered ALU operand B
- alu_sel  out  4  registered ALU select: 0 AND, 1 OR, 2 ADD, 6 SUB, 15 illegal (ALU yields 0)
- alu_out  in  n  ALU result, combinational from alu_a/alu_b/alu_sel
- alu_zero  in  1  ALU zero flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  n  captured ALU result
- rsp_zero  out  1  captured zero flag
- rsp_taken  out  1  branch taken (0 for non-branch ops)
- rsp_illegal  out  1  request did not decode to a legal op
- illegal_cnt  out  8  saturating count of illegal requests since reset

## Operation
- Decode in IDLE, from the request fields; results are latched on acceptance.
  - R-type, opcode 0110011, A=rs1, B=rs2:
    - f3=000, f7b5=0: sel 2.
    - f3=000, f7b5=1: sel 6.
    - f3=111: sel 0.
    - f3=110: sel 1.
    - Any other f3: illegal.
  - I-type, opcode 0010011, A=rs1, B=imm, f7b5 ignored:
    - f3=000: sel 2.
    - f3=111: sel 0.
    - f3=110: sel 1.
    - Any other f3: illegal.
  - Load 0000011 / store 0100011: sel 2, A=rs1, B=imm, funct3 ignored.
  - Branch 1100011: sel 6, A=rs1, B=rs2.
    - f3=000 is BEQ; f3=001 is BNE.
    - Any other f3: illegal.
  - Any other opcode: illegal.
  - Illegal requests: sel 15, A=B=0.
- FSM states:
  - IDLE: req_ready=1. When req_valid is high, latch alu_a, alu_b, alu_sel, the branch kind and the illegal bit, then go to EXEC.
  - EXEC: req_ready=0. At the edge, capture rsp_result=alu_out and rsp_zero=alu_zero. Compute rsp_taken = (BEQ & alu_zero) | (BNE & ~alu_zero). Copy the latched illegal bit to rsp_illegal. Go to RESP.
  - RESP: rsp_valid=1. Outputs are held stable until rsp_ready is high at an edge, then go to IDLE.
- alu_a, alu_b and alu_sel hold their value from acceptance until the next acceptance.
- rsp_* data is meaningful only while rsp_valid=1 and holds its value after leaving RESP.
- illegal_cnt increments on acceptance of an illegal request and saturates at 255.
- Arithmetic width is n bits. Carries and overflow are discarded by the ALU and are not reported.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, alu_a=alu_b=0, alu_sel=0, rsp_result=0, rsp_zero=0, rsp_taken=0, rsp_illegal=0, illegal_cnt=0.
- Latency:
  - Request accepted at edge k.
  - ALU inputs are valid after edge k.
  - Result captured at edge k+1.
  - rsp_valid=1 after edge k+1.
  - The earliest response handshake is at edge k+2.
  - The next acceptance is no earlier than edge k+3.
- The minimum issue interval is 3 cycles. req_ready=0 in EXEC and RESP, including the cycle in which rsp_ready completes.
- rsp_ready held high before rsp_valid is legal and completes at the first RESP edge.
- req_valid is ignored outside IDLE; no request is queued.
- Asynchronous reset mid-transaction: the transaction is dropped, rsp_valid goes to 0 immediately, and all registers take their reset values without waiting for clk.

## Test plan
- ADD then SUB:
  - R-type f3=000 f7b5=0, rs1=5, rs2=7 -> alu_sel=2 one cycle after acceptance; response result=12, zero=0, illegal=0, rsp_valid 2 cycles after acceptance.
  - Same with f7b5=1 -> result=0xFFFFFFFE.
- Branch: BEQ rs1=rs2=0x1234 -> sel=6, result=0, zero=1, taken=1. BNE with the same operands -> taken=0.
- I-type ORI rs1=0xF0, imm=0x0F -> sel=1, alu_b=0x0F, result=0xFF. Load rs1=0x100, imm=0xFFFFFFFC -> result=0xFC.
- Illegal:
  - R-type f3=001 -> sel=15, result=0, illegal=1, illegal_cnt=1.
  - 300 illegal requests -> illegal_cnt saturates at 255.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0, a second req_valid is not accepted. Release -> handshake, IDLE the next cycle.
- Reset: assert rst_n=0 during EXEC -> rsp_valid=0 and state IDLE asynchronously. After release, a new ADD 1+1 returns 2.
